temporal_encoder: RTL and testbench
===================================

// Module: temporal_encoder
// PURPOSE
//   Binary-to-temporal spike encoder; feeds exclusive-max/race-logic inputs.
//   Accepts one binary spike time per gamma cycle on a valid/ready port.
//   Emits it on q as a pulse whose rising edge falls at that clock offset in the next gamma cycle.
//   Also drives gamma_start so downstream temporal blocks stay gamma-aligned.
// PARAMETERS
//   GAMMA_CYCLE_WIDTH  16  aclk cycles per gamma cycle; legal range >=2.
//   PULSE_WIDTH        8   q high-time in aclk cycles; legal range 1..GAMMA_CYCLE_WIDTH.
//   TIME_W             $clog2(GAMMA_CYCLE_WIDTH)  width of in_time (localparam).
// PORTS
//   aclk        in   1       single clock, all flops rising-edge.
//   grst_n      in   1       asynchronous, active-low reset.
//   in_valid    in   1       in_time/in_null valid.
//   in_ready    out  1       encoder can accept; transfer = in_valid & in_ready.
//   in_time     in   TIME_W  spike offset within gamma cycle.
//   in_null     in   1       1 = no spike ("infinity") this gamma cycle.
//   gamma_start out  1       high while gcnt==0, i.e. first cycle of each gamma cycle.
//   q           out  1       temporal output, registered, glitch-free.
// BEHAVIOUR
//   Reset (grst_n=0, async): gcnt=0, stage empty, active=null, q=0.
//     While in reset: gamma_start=1 and in_ready=1.
//     Reset mid-pulse drops q to 0 immediately and discards stage and active.
//   gcnt: free-running 0..G-1, wraps to 0; boundary cycle = gcnt==G-1.
//   Two registers: stage {full,null,time} and active {null,time}.
//   in_ready = !stage.full | (gcnt==G-1).
//   Transfer loads stage; stage.full=1.
//   At boundary edge: active<=stage if stage.full, else active<=null.
//     Then stage<=transfer data if a transfer occurs that same cycle; else stage.full<=0.
//     So a boundary-cycle transfer is never lost and never overwrites the entry being promoted.
//   Latency: value accepted in gamma k is emitted in gamma k+1.
//   Backpressure: a 2nd transfer in the same gamma stalls until the boundary cycle.
//   in_time >= G (G not power of 2) is treated as null.
//   Pulse: q=1 in exactly those cycles where active!=null and t <= gcnt <= min(t+PULSE_WIDTH-1, G-1).
//     Pulses are clipped at the gamma end; they never spill into the next gamma.
//     Back-to-back gammas with t=0 and PULSE_WIDTH=G give a continuous q.
//   FSM (per gamma): IDLE (gcnt<t or null) -> FIRE (q=1, width counter runs) -> DONE (q=0 until boundary).
//     Every state returns to IDLE at the boundary.
//   A null active entry keeps q=0 for the whole gamma.
// CONFIGURATION
//   TEMPORAL_STEP_EN defined: step encoding.
//     q rises at gcnt==t and stays high through gcnt==G-1; PULSE_WIDTH is ignored.
//     This format suits rising-edge race-logic consumers.
//   Undefined (default): pulse encoding as in BEHAVIOUR.
// STRUCTURE
//   Package tnn_temporal_pkg:
//     - typedef enum {IDLE,FIRE,DONE} enc_state_e.
//     - function gamma_last(G) returns G-1.
//     - typedef struct spike_t {logic null; logic [TIME_W-1:0] t} as a parameterised-width helper macro.
//   Sub-module gamma_counter (GAMMA_CYCLE_WIDTH):
//     outputs gcnt, gamma_start and last; reused by temporal receivers.
//   Encoder top = stage/active registers + FSM + width counter.
// TESTING (G=16, PW=8 unless noted)
//   1. Release reset; send t=3 in gamma 0 -> gamma 1 gcnt 3..10: q=1; q=0 elsewhere.
//      gamma_start=1 at each gcnt==0.
//   2. Send t=12 -> q=1 for gcnt 12..15 only (clipped); next gamma q=0 when no input follows.
//   3. Two transfers in one gamma (t=2 then t=5):
//      - second stalls with in_ready=0 until gcnt==15, then is accepted;
//      - outputs: pulse @2 in gamma k+1, pulse @5 in gamma k+2.
//   4. Transfer exactly on gcnt==15 with stage full (t=1 staged, new t=4):
//      - t=1 fires in the next gamma, t=4 the one after;
//      - no loss and no duplicate.
//   5. in_null=1, then G=12 with in_time=13 -> q stays 0 for the full gamma in both cases.
//   6. Assert grst_n=0 at gcnt 5 of an active pulse:
//      - q=0 at once; gcnt=0, in_ready=1;
//      - after release, no stale pulse.
//   7. TEMPORAL_STEP_EN: t=6 -> q=1 for gcnt 6..15, falls at boundary.

Source files
------------

// File: rtl/temporal_encoder_pkg.sv
// ---------------------------------------------------------------------------
// tnn_temporal_pkg
//   Shared types and helpers for temporal (race-logic) encoders and receivers.
//   - enc_state_e : per-gamma encoder FSM states
//   - gamma_last  : gcnt value of the boundary cycle for a gamma length
//   - TNN_SPIKE_T : macro producing a packed spike struct of a given time
//                   width, {is_null, t}; is_null=1 means "no spike" (infinity)
// ---------------------------------------------------------------------------
`ifndef TNN_TEMPORAL_PKG_SV
`define TNN_TEMPORAL_PKG_SV

`define TNN_SPIKE_T(W) struct packed { logic is_null; logic [(W)-1:0] t; }

package tnn_temporal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  function automatic int gamma_last(input int g);
    return g - 1;
  endfunction

endpackage

`endif

// File: rtl/temporal_encoder_if.sv
// ---------------------------------------------------------------------------
// temporal_encoder_if
//   Spike-time input handshake plus the temporal outputs of the encoder.
//   master : producer side (drives in_valid/in_time/in_null)
//   slave  : encoder side (drives in_ready/gamma_start/q)
//   in_valid    spike entry valid
//   in_ready    encoder can accept; transfer = in_valid & in_ready
//   in_time     spike offset within the gamma cycle
//   in_null     1 = no spike this gamma cycle
//   gamma_start high during the first cycle of every gamma cycle
//   q           registered temporal output
// ---------------------------------------------------------------------------
interface temporal_encoder_if #(
  parameter int TIME_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] in_time;
  logic              in_null;
  logic              gamma_start;
  logic              q;

  modport master (
    output in_valid, in_time, in_null,
    input  in_ready, gamma_start, q
  );

  modport slave (
    input  in_valid, in_time, in_null,
    output in_ready, gamma_start, q
  );
endinterface

// File: rtl/temporal_encoder_gamma_counter.sv
// ---------------------------------------------------------------------------
// gamma_counter
//   Free-running gamma-cycle counter 0..GAMMA_CYCLE_WIDTH-1, shared by the
//   temporal encoder and temporal receivers so all stay gamma-aligned.
//   aclk          clock, rising edge
//   grst_n        asynchronous active-low reset (counter held at 0)
//   o_gcnt        current offset within the gamma cycle
//   o_gamma_start high while o_gcnt == 0 (also high during reset)
//   o_last        high in the boundary cycle (o_gcnt == G-1)
// ---------------------------------------------------------------------------
module gamma_counter
  import tnn_temporal_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  localparam int TIME_W            = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic              aclk,
  input  logic              grst_n,
  output logic [TIME_W-1:0] o_gcnt,
  output logic              o_gamma_start,
  output logic              o_last
);

  localparam logic [TIME_W-1:0] LAST = TIME_W'(gamma_last(GAMMA_CYCLE_WIDTH));

  logic [TIME_W-1:0] r_gcnt;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_gcnt <= '0;
    end else if (r_gcnt == LAST) begin
      r_gcnt <= '0;
    end else begin
      r_gcnt <= r_gcnt + 1'b1;
    end
  end

  assign o_gcnt        = r_gcnt;
  assign o_gamma_start = (r_gcnt == '0);
  assign o_last        = (r_gcnt == LAST);

endmodule

// File: rtl/temporal_encoder.sv
// ---------------------------------------------------------------------------
// temporal_encoder
//   Binary-to-temporal spike encoder. One spike time is accepted per gamma
//   cycle and emitted in the following gamma cycle on q, with q rising at
//   that offset. A two-entry pipeline (stage -> active) decouples input
//   timing from emission: stage collects the entry for the next gamma,
//   active is the entry being emitted now.
//
//   Build option TEMPORAL_STEP_EN (macro): when defined, q is a step that
//   stays high from offset t to the end of the gamma (PULSE_WIDTH unused);
//   when undefined, q is a pulse of PULSE_WIDTH cycles clipped at the gamma
//   end.
//
//   aclk    clock, rising edge
//   grst_n  asynchronous active-low reset
//   bus     temporal_encoder_if.slave (in_valid/in_ready/in_time/in_null,
//           gamma_start, q)
//
//   state | meaning
//   IDLE  | waiting for gcnt to reach active.t, or active entry is null
//   FIRE  | q high; pulse width counter running
//   DONE  | pulse finished, q low until the gamma boundary
// ---------------------------------------------------------------------------
module temporal_encoder
  import tnn_temporal_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  parameter  int PULSE_WIDTH       = 8,
  localparam int TIME_W            = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic               aclk,
  input  logic               grst_n,
  temporal_encoder_if.slave  bus
);

  typedef `TNN_SPIKE_T(TIME_W) spike_t;

  localparam spike_t NULL_SPIKE = '{is_null: 1'b1, t: '0};

  logic [TIME_W-1:0] w_gcnt;
  logic [TIME_W-1:0] w_gcnt_nxt;
  logic              w_gamma_start;
  logic              w_last;
  logic              w_xfer;
  logic              w_in_null;
  logic              w_fire_start;
  spike_t            w_in_spike;
  spike_t            w_active_nxt;

  logic              r_stage_full;
  spike_t            r_stage;
  spike_t            r_active;
  enc_state_e        r_state;
  enc_state_e        w_state_nxt;
  logic              r_q;

`ifndef TEMPORAL_STEP_EN
  localparam logic [TIME_W-1:0] CNT_LOAD = TIME_W'(PULSE_WIDTH - 1);
  logic [TIME_W-1:0] r_wcnt;
  logic [TIME_W-1:0] w_wcnt_nxt;
`endif

  gamma_counter #(
    .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH)
  ) u_gamma_counter (
    .aclk          (aclk),
    .grst_n        (grst_n),
    .o_gcnt        (w_gcnt),
    .o_gamma_start (w_gamma_start),
    .o_last        (w_last)
  );

  // Times beyond the gamma length can only occur for non-power-of-2 G and
  // are folded into "no spike" at capture time.
  assign w_in_null  = bus.in_null | (int'(bus.in_time) >= GAMMA_CYCLE_WIDTH);
  assign w_in_spike = '{is_null: w_in_null, t: bus.in_time};

  // The boundary cycle always accepts: stage is promoted on that same edge,
  // so the incoming entry lands in a freed stage.
  assign bus.in_ready    = !r_stage_full | w_last;
  assign bus.gamma_start = w_gamma_start;
  assign bus.q           = r_q;
  assign w_xfer          = bus.in_valid & bus.in_ready;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_stage_full <= 1'b0;
      r_stage      <= NULL_SPIKE;
      r_active     <= NULL_SPIKE;
    end else begin
      if (w_last) begin
        r_active <= w_active_nxt;
      end
      if (w_xfer) begin
        r_stage_full <= 1'b1;
        r_stage      <= w_in_spike;
      end else if (w_last) begin
        r_stage_full <= 1'b0;
      end
    end
  end

  // The FSM computes the state of the next cycle from the next-cycle gcnt
  // and active entry, so q can be a plain flop that is high in exactly the
  // cycles where the pulse belongs.
  always_comb begin
    w_gcnt_nxt   = w_last ? '0 : w_gcnt + 1'b1;
    w_active_nxt = r_active;
    if (w_last) begin
      w_active_nxt = r_stage_full ? r_stage : NULL_SPIKE;
    end
    w_fire_start = !w_active_nxt.is_null && (w_gcnt_nxt == w_active_nxt.t);
  end

  always_comb begin
    w_state_nxt = r_state;
`ifndef TEMPORAL_STEP_EN
    w_wcnt_nxt  = r_wcnt;
`endif
    if (w_last || (r_state == IDLE)) begin
      w_state_nxt = IDLE;
      if (w_fire_start) begin
        w_state_nxt = FIRE;
`ifndef TEMPORAL_STEP_EN
        w_wcnt_nxt  = CNT_LOAD;
`endif
      end
    end else if (r_state == FIRE) begin
`ifndef TEMPORAL_STEP_EN
      if (r_wcnt == '0) begin
        w_state_nxt = DONE;
      end else begin
        w_wcnt_nxt = r_wcnt - 1'b1;
      end
`else
      w_state_nxt = FIRE;
`endif
    end else if (r_state != DONE) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_state <= IDLE;
      r_q     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= (w_state_nxt == FIRE);
    end
  end

`ifndef TEMPORAL_STEP_EN
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= w_wcnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_temporal_encoder.sv
// Two encoders share clock and reset: dut_a (G=16, PW=8) and dut_b (G=12, PW=5).
// The reference model records, per gamma index, which spike time is due to be
// emitted, and derives q / in_ready / gamma_start from that schedule.
module tb_temporal_encoder;
  localparam int GA = 16, PA = 8, GB = 12, PB = 5, TW = 4;
  localparam int NONE = -2, NUL = -1, NG = 1024;

  logic aclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 aclk = ~aclk;

  temporal_encoder_if #(.TIME_W(TW)) if_a ();
  temporal_encoder_if #(.TIME_W(TW)) if_b ();

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(GA), .PULSE_WIDTH(PA)) dut_a (
    .aclk(aclk), .grst_n(grst_n), .bus(if_a));
  temporal_encoder #(.GAMMA_CYCLE_WIDTH(GB), .PULSE_WIDTH(PB)) dut_b (
    .aclk(aclk), .grst_n(grst_n), .bus(if_b));

  int checks = 0;
  int errors = 0;
  int g [2];
  int c [2];
  int sched [2][NG];
  logic drv_v [2];
  logic drv_n [2];
  logic [TW-1:0] drv_t [2];
  bit acc [2];

  function automatic int gsz(int d); return (d == 0) ? GA : GB; endfunction
  function automatic int pw(int d);  return (d == 0) ? PA : PB; endfunction

  function automatic logic exp_q(int d);
    int s = sched[d][g[d] % NG];
    int gl = gsz(d);
    int hi;
    if (s < 0 || s >= gl) return 1'b0;
`ifdef TEMPORAL_STEP_EN
    hi = gl - 1;
`else
    hi = (s + pw(d) - 1 < gl - 1) ? s + pw(d) - 1 : gl - 1;
`endif
    return (c[d] >= s) && (c[d] <= hi);
  endfunction

  function automatic logic exp_ready(int d);
    return (c[d] == gsz(d) - 1) || (sched[d][(g[d] + 1) % NG] == NONE);
  endfunction

  function automatic logic got_q(int d);   return (d == 0) ? if_a.q : if_b.q; endfunction
  function automatic logic got_gs(int d);  return (d == 0) ? if_a.gamma_start : if_b.gamma_start; endfunction
  function automatic logic got_rdy(int d); return (d == 0) ? if_a.in_ready : if_b.in_ready; endfunction

  task automatic chk(string tag, int d, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d gamma %0d gcnt %0d observed %b expected %b", tag, d, g[d], c[d], obs, expv);
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      chk("q", d, got_q(d), exp_q(d));
      chk("gamma_start", d, got_gs(d), (c[d] == 0));
      chk("in_ready", d, got_rdy(d), exp_ready(d));
      acc[d] = drv_v[d] && exp_ready(d);
      if (acc[d])
        sched[d][(g[d] + 1 + ((c[d] == gsz(d) - 1) ? 1 : 0)) % NG] = drv_n[d] ? NUL : int'(drv_t[d]);
    end
    if_a.in_valid = drv_v[0]; if_a.in_null = drv_n[0]; if_a.in_time = drv_t[0];
    if_b.in_valid = drv_v[1]; if_b.in_null = drv_n[1]; if_b.in_time = drv_t[1];
    @(posedge aclk);
    @(negedge aclk);
    for (int d = 0; d < 2; d++) begin
      c[d]++;
      if (c[d] == gsz(d)) begin
        c[d] = 0;
        g[d]++;
      end
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(int d, int t, bit nul);
    drv_v[d] = 1'b1; drv_t[d] = TW'(t); drv_n[d] = nul;
    acc[d] = 1'b0;
    for (int k = 0; k < 3 * GA; k++) begin
      tick();
      if (acc[d]) break;
    end
    if (!acc[d]) begin
      errors++;
      $error("FAIL send_timeout dut%0d observed no accept expected accept", d);
    end
    drv_v[d] = 1'b0;
  endtask

  task automatic do_reset();
    grst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_q", d, got_q(d), 1'b0);
      chk("rst_gamma_start", d, got_gs(d), 1'b1);
      chk("rst_in_ready", d, got_rdy(d), 1'b1);
    end
    @(negedge aclk);
    @(negedge aclk);
    grst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      g[d] = 0; c[d] = 0;
      for (int i = 0; i < NG; i++) sched[d][i] = NONE;
    end
  endtask

  initial begin
    bit hit;
    for (int d = 0; d < 2; d++) begin
      drv_v[d] = 1'b0; drv_n[d] = 1'b0; drv_t[d] = '0; acc[d] = 1'b0;
    end
    if_a.in_valid = 1'b0; if_a.in_null = 1'b0; if_a.in_time = '0;
    if_b.in_valid = 1'b0; if_b.in_null = 1'b0; if_b.in_time = '0;
    @(negedge aclk);
    do_reset();

    // basic pulse, then a clipped pulse followed by an empty gamma
    send(0, 3, 1'b0);
    idle(2 * GA);
    send(0, 12, 1'b0);
    idle(2 * GA);

    // two transfers in one gamma: the second stalls to the boundary
    send(0, 2, 1'b0);
    send(0, 5, 1'b0);
    idle(3 * GA);

    // stage full plus boundary transfer, then t=0 at the gamma start
    send(0, 1, 1'b0);
    send(0, 4, 1'b0);
    send(0, 0, 1'b0);
    idle(3 * GA);

    // null entries on both encoders, out-of-range time on the G=12 encoder
    send(1, 7, 1'b1);
    idle(2 * GA);
    send(1, 13, 1'b0);
    idle(2 * GA);
    send(1, 9, 1'b0);
    send(1, 11, 1'b0);
    idle(3 * GA);
    send(0, 6, 1'b1);
    idle(2 * GA);

    // reset in the middle of an active pulse, then no stale output
    send(0, 3, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 3 * GA; k++) begin
      if (sched[0][g[0] % NG] == 3 && c[0] == 5) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) begin
      errors++;
      $error("FAIL midpulse_wait observed no pulse window expected gcnt 5 of active gamma");
    end
    chk("pre_rst_q", 0, got_q(0), exp_q(0));
    do_reset();
    idle(3 * GA);

    // randomized traffic on both encoders, valid held until accepted
    for (int k = 0; k < 2400; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (!drv_v[d] && $urandom_range(0, 3) == 0) begin
          drv_v[d] = 1'b1;
          drv_n[d] = ($urandom_range(0, 7) == 0);
          drv_t[d] = TW'($urandom_range(0, 15));
        end
      end
      tick();
      for (int d = 0; d < 2; d++) if (acc[d]) drv_v[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) drv_v[d] = 1'b0;
    idle(3 * GA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
